alu_arbiter: RTL

Two-port arbiter and sequencer that shares a single `simple_alu` instance between two independent requesters. Each requester presents operands and an opcode on a valid/ready request channel and receives the 9-bit result on a valid/ready response channel. The block grants requesters round-robin and drives the ALU operand and opcode registers. It waits a fixed ALU latency, captures the result, and returns it only to the requester that issued the operation. One operation is in flight at a time.

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 23 ++
 rtl/rr_arb2.sv | 10 +
 rtl/simple_alu.sv | 40 ++++
 rtl/alu_arbiter.sv | 88 ++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-port ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int OPERAND_W = 8;
  localparam int OPCODE_W  = 2;
  localparam int RESULT_W  = 9;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel pair; master is the requester side.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OPERAND_W-1:0] req_a;
  logic [OPERAND_W-1:0] req_b;
  logic [OPCODE_W-1:0]  req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RESULT_W-1:0]  rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       any,
  output logic       winner
);
  assign any    = |valid;
  assign winner = (&valid) ? ~last : valid[1];
endmodule

// File: rtl/simple_alu.sv
// Small ALU used next to the arbiter: add, subtract, and, or with LATENCY-1 pipeline stages.
module simple_alu #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic [7:0] operandA,
  input  logic [7:0] operandB,
  input  logic [1:0] opcode,
  output logic [8:0] result
);
  logic [8:0] comb_res;

  always_comb begin
    comb_res = '0;
    case (opcode)
      2'b00:   comb_res = {1'b0, operandA} + {1'b0, operandB};
      2'b01:   comb_res = {1'b0, operandA} - {1'b0, operandB};
      2'b10:   comb_res = {1'b0, operandA & operandB};
      default: comb_res = {1'b0, operandA | operandB};
    endcase
  end

  // Latency counts from the operand change, so one cycle of it is the combinational path.
  generate
    if (LATENCY <= 1) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk;
      assign result     = comb_res;
    end else begin : g_pipe
      logic [8:0] pipe_reg [LATENCY-1];
      always_ff @(posedge clk) begin
        pipe_reg[0] <= comb_res;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign result = pipe_reg[LATENCY-2];
    end
  endgenerate
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, fixed-latency wait,
// result returned only to the requester that issued the operation.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_arbiter_if.slave         port0,
  alu_arbiter_if.slave         port1,
  output logic [OPERAND_W-1:0] alu_operandA,
  output logic [OPERAND_W-1:0] alu_operandB,
  output logic [OPCODE_W-1:0]  alu_opcode,
  input  logic [RESULT_W-1:0]  alu_result
);
  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                grant_reg;
  logic                last_reg;
  logic [RESULT_W-1:0] res_reg;

  logic [1:0] valid_vec;
  logic       any_valid;
  logic       winner;
  logic       in_idle;
  logic       rsp_ready_sel;

  assign valid_vec = {port1.req_valid, port0.req_valid};

  rr_arb2 u_rr (
    .valid  (valid_vec),
    .last   (last_reg),
    .any    (any_valid),
    .winner (winner)
  );

  assign in_idle         = (state_reg == IDLE);
  assign port0.req_ready = in_idle && any_valid && !winner;
  assign port1.req_ready = in_idle && any_valid && winner;

  assign port0.rsp_valid  = (state_reg == RESP) && !grant_reg;
  assign port1.rsp_valid  = (state_reg == RESP) && grant_reg;
  assign port0.rsp_result = res_reg;
  assign port1.rsp_result = res_reg;
  assign rsp_ready_sel    = grant_reg ? port1.rsp_ready : port0.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      grant_reg    <= 1'b0;
      last_reg     <= 1'b1;
      res_reg      <= '0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      alu_opcode   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // In IDLE the winner's ready is high, so any valid request is a handshake.
          if (any_valid) begin
            alu_operandA <= winner ? port1.req_a  : port0.req_a;
            alu_operandB <= winner ? port1.req_b  : port0.req_b;
            alu_opcode   <= winner ? port1.req_op : port0.req_op;
            grant_reg    <= winner;
            last_reg     <= winner;
            cnt_reg      <= CNT_W'(ALU_LATENCY);
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            res_reg   <= alu_result;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_sel) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
